// File: rtl/e32_host_mode_driver.sv
// Host-side E32 mode pin driver: sequences M1/M0 changes against the
// transceiver's AUX busy/free handshake and reports done or AUX timeout.
module e32_host_mode_driver #(
  parameter logic [1:0]  DEFAULT_MODE  = 2'd3,
  parameter int unsigned AUX_LOW_WAIT  = 64,
  parameter int unsigned AUX_TIMEOUT   = 100000,
  parameter int unsigned SETTLE_CYCLES = 2000
) (
  input  logic       internal_clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       AUX,
  output logic       M0,
  output logic       M1,
  output logic [1:0] cur_mode,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int unsigned MAX_AB = (AUX_TIMEOUT > SETTLE_CYCLES) ? AUX_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_AB > AUX_LOW_WAIT) ? MAX_AB : AUX_LOW_WAIT;
  localparam int unsigned CW     = $clog2(MAX_C + 1);

  // Terminal values are N-1: a wait of N cycles ends on the Nth cycle in state.
  localparam logic [CW-1:0] TO_LAST     = CW'(AUX_TIMEOUT - 1);
  localparam logic [CW-1:0] LOW_LAST    = CW'(AUX_LOW_WAIT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_FREE = 3'd2,
    ST_DRIVE     = 3'd3,
    ST_WAIT_LOW  = 3'd4,
    ST_WAIT_HIGH = 3'd5,
    ST_SETTLE    = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    pins_q, pins_d;
  logic          from_init_q, from_init_d;
  logic          aux_meta_q, aux_s_q;
  logic          ready_q, busy_q, done_q, timeout_q;
  logic          timeout_s;

  // AUX synchroniser.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_meta_q <= 1'b0;
      aux_s_q    <= 1'b0;
    end else begin
      aux_meta_q <= AUX;
      aux_s_q    <= aux_meta_q;
    end
  end

  // Next-state, counter and pin logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pins_d      = pins_q;
    from_init_d = from_init_q;
    timeout_s   = 1'b0;
    cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    case (state_q)
      ST_INIT: begin
        if (aux_s_q) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          mode_d      = req_mode;
          from_init_d = 1'b0;
          state_d     = (req_mode == pins_q) ? ST_DONE : ST_WAIT_FREE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FREE: begin
        if (aux_s_q) begin
          state_d = ST_DRIVE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_d = ST_WAIT_FREE;
        end
      end
      ST_DRIVE: begin
        pins_d  = mode_q;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // AUX may never drop for switches that need no parameter reload.
        if (!aux_s_q) begin
          state_d = ST_WAIT_HIGH;
        end else if (cnt_q == LOW_LAST) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        if (aux_s_q) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_SETTLE: begin
        if (!aux_s_q) begin
          state_d = ST_WAIT_HIGH;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = from_init_q ? ST_IDLE : ST_DONE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    cnt_d = (state_d != state_q) ? CNT_ZERO : cnt_inc_s;
  end

  // State, counter, pins and registered status outputs.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= CNT_ZERO;
      mode_q      <= DEFAULT_MODE;
      pins_q      <= DEFAULT_MODE;
      from_init_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pins_q      <= pins_d;
      from_init_q <= from_init_d;
      ready_q     <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_q == ST_DONE);
      timeout_q   <= timeout_s;
    end
  end

  assign M1          = pins_q[1];
  assign M0          = pins_q[0];
  assign cur_mode    = pins_q;
  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule
